// File: rtl/sha256_padder.sv
// SHA-256 message preprocessor: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and the big-endian message bit length.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_keep,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);
  // state | meaning
  // FILL  | collecting message bytes into the block buffer
  // EMIT  | block presented to the core, held until blk_ready
  // PAD   | building the extra length-only block after an overflowing tail
  typedef enum logic [1:0] {FILL = 2'd0, EMIT = 2'd1, PAD = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [511:0]     r_buf, w_buf_nxt;
  logic [5:0]       r_idx, w_idx_nxt;
  logic [LEN_W-1:0] r_bitlen, w_bitlen_nxt;
  logic             r_first_pending, w_first_pending_nxt;
  logic             r_pad_pending, w_pad_pending_nxt;
  logic             r_k_full, w_k_full_nxt;
  logic             r_blk_first, w_blk_first_nxt;
  logic             r_blk_last, w_blk_last_nxt;

  logic             w_accept;
  logic [LEN_W-1:0] w_bitlen_inc;
  logic [6:0]       w_n;
  logic [511:0]     w_buf_wr;
  logic [511:0]     w_buf_fin;

  assign w_accept     = in_valid && (r_state == FILL);
  assign w_bitlen_inc = in_keep ? r_bitlen + LEN_W'(8) : r_bitlen;
  // bytes in the block once the current transfer lands, 0..64
  assign w_n          = {1'b0, r_idx} + {6'd0, in_keep};

  always_comb begin
    w_buf_wr = r_buf;
    for (int s = 0; s < 64; s++) begin
      if (in_keep && (r_idx == 6'(s))) w_buf_wr[511-8*s -: 8] = in_data;
    end
  end

  // Tail padding: marker at slot n, zeros after, length only if it still fits.
  always_comb begin
    w_buf_fin = w_buf_wr;
    for (int s = 0; s < 64; s++) begin
      if (7'(s) == w_n)     w_buf_fin[511-8*s -: 8] = 8'h80;
      else if (7'(s) > w_n) w_buf_fin[511-8*s -: 8] = 8'h00;
    end
    if (w_n <= 7'd55) w_buf_fin[63:0] = 64'(w_bitlen_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= FILL;
      r_buf           <= '0;
      r_idx           <= '0;
      r_bitlen        <= '0;
      r_first_pending <= 1'b1;
      r_pad_pending   <= 1'b0;
      r_k_full        <= 1'b0;
      r_blk_first     <= 1'b0;
      r_blk_last      <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_buf           <= w_buf_nxt;
      r_idx           <= w_idx_nxt;
      r_bitlen        <= w_bitlen_nxt;
      r_first_pending <= w_first_pending_nxt;
      r_pad_pending   <= w_pad_pending_nxt;
      r_k_full        <= w_k_full_nxt;
      r_blk_first     <= w_blk_first_nxt;
      r_blk_last      <= w_blk_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_buf_nxt           = r_buf;
    w_idx_nxt           = r_idx;
    w_bitlen_nxt        = r_bitlen;
    w_first_pending_nxt = r_first_pending;
    w_pad_pending_nxt   = r_pad_pending;
    w_k_full_nxt        = r_k_full;
    w_blk_first_nxt     = r_blk_first;
    w_blk_last_nxt      = r_blk_last;
    unique case (r_state)
      FILL: begin
        if (w_accept) begin
          if (in_last) begin
            w_buf_nxt           = w_buf_fin;
            w_bitlen_nxt        = w_bitlen_inc;
            w_idx_nxt           = r_idx + 6'(in_keep);
            w_state_nxt         = EMIT;
            w_blk_first_nxt     = r_first_pending;
            w_first_pending_nxt = 1'b0;
            w_blk_last_nxt      = (w_n <= 7'd55);
            w_pad_pending_nxt   = (w_n > 7'd55);
            w_k_full_nxt        = (w_n == 7'd64);
          end else if (in_keep) begin
            w_buf_nxt    = w_buf_wr;
            w_bitlen_nxt = w_bitlen_inc;
            w_idx_nxt    = r_idx + 6'd1;
            if (r_idx == 6'd63) begin
              w_state_nxt         = EMIT;
              w_blk_first_nxt     = r_first_pending;
              w_first_pending_nxt = 1'b0;
              w_blk_last_nxt      = 1'b0;
            end
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          w_buf_nxt       = '0;
          w_idx_nxt       = '0;
          w_blk_first_nxt = 1'b0;
          w_state_nxt     = r_pad_pending ? PAD : FILL;
          if (r_blk_last) begin
            w_bitlen_nxt        = '0;
            w_first_pending_nxt = 1'b1;
          end
        end
      end
      PAD: begin
        w_buf_nxt          = '0;
        w_buf_nxt[511:504] = r_k_full ? 8'h80 : 8'h00;
        w_buf_nxt[63:0]    = 64'(r_bitlen);
        w_state_nxt        = EMIT;
        w_blk_last_nxt     = 1'b1;
        w_pad_pending_nxt  = 1'b0;
        w_k_full_nxt       = 1'b0;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  assign in_ready  = (r_state == FILL) && !reset;
  assign blk_valid = (r_state == EMIT);
  assign blk_data  = blk_valid ? r_buf : '0;
  assign blk_first = blk_valid && r_blk_first;
  assign blk_last  = blk_valid && r_blk_last;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: random and directed messages checked against a
// plain SHA-256 padding model (append 0x80, zero-fill, 64-bit length, split).
module tb_sha256_padder;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic         pad_follows;
  } blk_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         in_keep = 1'b0;
  logic         blk_ready = 1'b1;
  logic         in_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  sha256_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_keep   (in_keep),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  blk_t exp_q[$];
  int   bp_mode = 2;  // 0 random ready, 1 ready held low, 2 ready held high

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_blk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: standard SHA-256 padding of the whole message, then split into blocks.
  task automatic model_blocks(input bq_t msg, input bit em, output blk_t blks[$]);
    bq_t         p;
    logic [63:0] len;
    int          L, n, nb;
    blk_t        b;
    p   = msg;
    L   = msg.size();
    len = 64'(L) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    nb = p.size() / 64;
    if (em) n = L % 64;
    else    n = ((L - 1) % 64) + 1;
    blks.delete();
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[64*k+j];
      b.first       = (k == 0);
      b.last        = (k == nb - 1);
      b.pad_follows = (k == nb - 2) && (n >= 56);
      blks.push_back(b);
    end
  endtask

  task automatic str2q(input string s, output bq_t q);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic rep2q(input logic [7:0] v, input int cnt, output bq_t q);
    q.delete();
    for (int i = 0; i < cnt; i++) q.push_back(v);
  endtask

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       blk_ready = ($urandom_range(0, 3) != 0);
      1:       blk_ready = 1'b0;
      default: blk_ready = 1'b1;
    endcase
  end

  logic         prev_stall = 1'b0;
  logic         prev_hs = 1'b0;
  logic [511:0] prev_data = '0;
  logic         prev_first = 1'b0;
  logic         prev_last = 1'b0;
  int           pad_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_hs    = 1'b0;
      pad_cnt    = 0;
    end else begin
      blk_t e;
      if (prev_hs) check_bit("one_cycle_valid", blk_valid, 1'b0);
      if (pad_cnt == 1) check_bit("pad_latency", blk_valid, 1'b1);
      if (pad_cnt > 0) pad_cnt--;
      if (prev_stall) begin
        check_bit("stall_valid", blk_valid, 1'b1);
        check_blk("stall_data", blk_data, prev_data);
        check_bit("stall_first", blk_first, prev_first);
        check_bit("stall_last", blk_last, prev_last);
      end
      if (blk_valid) check_bit("in_ready_while_valid", in_ready, 1'b0);
      prev_hs    = 1'b0;
      prev_stall = 1'b0;
      if (blk_valid && blk_ready) begin
        check_bit("block_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_blk("blk_data", blk_data, e.data);
          check_bit("blk_first", blk_first, e.first);
          check_bit("blk_last", blk_last, e.last);
          if (e.pad_follows) pad_cnt = 2;
        end
        prev_hs = 1'b1;
      end else if (blk_valid) begin
        prev_stall = 1'b1;
        prev_data  = blk_data;
        prev_first = blk_first;
        prev_last  = blk_last;
      end
    end
  end

  // Called and returns at a falling edge; the transfer lands on the rising edge in between.
  task automatic send_xfer(input logic [7:0] d, input logic last, input logic keep);
    int waitc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_keep  = keep;
    while (!in_ready) begin
      @(negedge clk);
      waitc++;
      if (waitc > 5000) begin
        n_fail++;
        $display("FAIL in_ready_timeout: in_ready stayed %b, required 1", in_ready);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "input handshake timed out");
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_keep  = 1'b0;
  endtask

  task automatic run_msg(input bq_t m, input bit em, input bit junk);
    blk_t b[$];
    int   L;
    L = m.size();
    model_blocks(m, em, b);
    foreach (b[k]) exp_q.push_back(b[k]);
    for (int i = 0; i < L; i++) begin
      if (junk) begin
        if ($urandom_range(0, 7) == 0) @(negedge clk);
        if ($urandom_range(0, 7) == 0) send_xfer(8'($urandom), 1'b0, 1'b0);
      end
      send_xfer(m[i], !em && (i == L - 1), 1'b1);
      if (((i + 1) % 64 == 0) || (!em && (i == L - 1)))
        check_bit("blk_latency", blk_valid, 1'b1);
    end
    if (em) begin
      send_xfer(8'($urandom), 1'b1, 1'b0);
      check_bit("blk_latency", blk_valid, 1'b1);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || blk_valid) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check_bit("drain", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    bq_t          m;
    blk_t         pb[$];
    logic [511:0] held;
    int           lens[13] = '{0, 1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};

    // pin the model against hand-computed blocks
    str2q("Hello, SHA-256!", m);
    model_blocks(m, 1'b0, pb);
    check_bit("pin_hello_single", pb.size() == 1, 1'b1);
    check_blk("pin_hello", pb[0].data, {128'h48656c6c6f2c205348412d3235362180, 320'h0, 64'h78});
    check_bit("pin_hello_flags", pb[0].first && pb[0].last, 1'b1);
    m.delete();
    model_blocks(m, 1'b1, pb);
    check_blk("pin_empty", pb[0].data, {8'h80, 504'h0});
    rep2q(8'h61, 55, m);
    model_blocks(m, 1'b0, pb);
    check_blk("pin_55", pb[0].data, {{55{8'h61}}, 8'h80, 64'h1b8});
    rep2q(8'h61, 56, m);
    model_blocks(m, 1'b0, pb);
    check_blk("pin_56_b0", pb[0].data, {{56{8'h61}}, 8'h80, 56'h0});
    check_blk("pin_56_b1", pb[1].data, {448'h0, 64'h1c0});
    rep2q(8'h61, 64, m);
    model_blocks(m, 1'b0, pb);
    check_blk("pin_64_b1", pb[1].data, {8'h80, 440'h0, 64'h200});
    check_bit("pin_64_b1_first", pb[1].first, 1'b0);
    str2q("abc", m);
    model_blocks(m, 1'b0, pb);
    check_blk("pin_abc", pb[0].data, {24'h616263, 8'h80, 416'h0, 64'h18});

    // reset values
    repeat (2) @(negedge clk);
    check_bit("reset_in_ready", in_ready, 1'b0);
    check_bit("reset_blk_valid", blk_valid, 1'b0);
    check_blk("reset_blk_data", blk_data, '0);
    reset = 1'b0;
    @(negedge clk);
    check_bit("post_reset_in_ready", in_ready, 1'b1);
    check_bit("post_reset_blk_valid", blk_valid, 1'b0);
    check_bit("post_reset_blk_first", blk_first, 1'b0);
    check_bit("post_reset_blk_last", blk_last, 1'b0);
    check_blk("post_reset_blk_data", blk_data, '0);

    // directed messages with the core always ready
    bp_mode = 2;
    str2q("Hello, SHA-256!", m);
    run_msg(m, 1'b0, 1'b0);
    m.delete();
    run_msg(m, 1'b1, 1'b0);
    rep2q(8'h61, 55, m);
    run_msg(m, 1'b0, 1'b0);
    rep2q(8'h61, 56, m);
    run_msg(m, 1'b0, 1'b0);
    rep2q(8'h61, 64, m);
    run_msg(m, 1'b0, 1'b0);
    rep2q(8'h62, 64, m);
    run_msg(m, 1'b1, 1'b0);
    wait_drain();

    // backpressure: hold the block for 5 cycles
    bp_mode = 1;
    repeat (2) @(negedge clk);
    str2q("xyz", m);
    run_msg(m, 1'b0, 1'b0);
    held = blk_data;
    repeat (5) begin
      @(negedge clk);
      check_blk("bp_hold_data", blk_data, held);
      check_bit("bp_in_ready", in_ready, 1'b0);
    end
    bp_mode = 2;
    wait_drain();

    // reset mid-message discards the partial block
    for (int i = 0; i < 10; i++) send_xfer(8'($urandom), 1'b0, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("abort_no_block", blk_valid, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_bit("abort_no_block_after", blk_valid, 1'b0);
    str2q("abc", m);
    run_msg(m, 1'b0, 1'b0);
    wait_drain();

    // randomized messages, random backpressure, idle gaps and ignored keep=0 transfers
    bp_mode = 0;
    for (int t = 0; t < 40; t++) begin
      int L;
      bit em;
      if ($urandom_range(0, 2) == 0) L = lens[$urandom_range(0, 12)];
      else L = $urandom_range(1, 150);
      em = (L == 0) || ($urandom_range(0, 1) == 1);
      m.delete();
      for (int i = 0; i < L; i++) m.push_back(8'($urandom));
      run_msg(m, em, 1'b1);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
